prio_enc_queue: RTL and testbench



---
 rtl/prio_enc_pkg.sv | 22 ++
 rtl/prio_enc_find.sv | 34 +++
 rtl/prio_enc_queue.sv | 103 ++++++++++
 tb/tb_prio_enc_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared constants and helpers for the priority-encoder queue
package prio_enc_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 8;
    // Widest request vector the one-hot helper can describe.
    localparam int MAX_N     = 64;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_N) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/prio_enc_find.sv
// rtl/prio_enc_find.sv - combinational search for the first set bit, descending from start with wrap
module prio_enc_find
    import prio_enc_pkg::*;
#(
    parameter  int N     = DEF_N,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin : find_c
        int s;
        int p;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        // An out-of-range start (non power-of-two N) behaves like the top index.
        s     = (int'(start) > N - 1) ? N - 1 : int'(start);
        for (int i = 0; i < N; i++) begin
            p = s - i;
            if (p < 0) begin
                p = p + N;
            end
            if (!found && vec[p]) begin
                found = 1'b1;
                idx   = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/prio_enc_queue.sv
// rtl/prio_enc_queue.sv - registered N-input priority encoder with request accumulation and valid/ready output
// Build option PRIO_ENC_ROUND_ROBIN_EN: rotating search start instead of fixed N-1 priority.
module prio_enc_queue
    import prio_enc_pkg::*;
#(
    parameter  int N     = DEF_N,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending_o,
    output logic [CNT_W-1:0] coalesce_cnt,
    input  logic             cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     r_pending;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;

    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    logic             w_load;
    logic [MAX_N-1:0] w_oh_full;
    logic [N-1:0]     w_clear;
    logic             w_hit;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_rr_ptr;
    assign w_start = r_rr_ptr;
`else
    assign w_start = IDX_W'(N - 1);
`endif

    prio_enc_find #(
        .N(N)
    ) u_find (
        .vec  (r_pending),
        .start(w_start),
        .idx  (w_idx),
        .found(w_found)
    );

    // A presented index is replaced only once it has been taken (or was never valid).
    assign w_load    = w_found & (~r_valid | out_ready);
    assign w_oh_full = onehot(int'(w_idx), N);
    assign w_clear   = w_load ? w_oh_full[N-1:0] : '0;
    assign w_hit     = |(req_i & r_pending & ~w_clear);

    generate
        if (N < MAX_N) begin : g_oh_spare
            logic w_unused_oh;
            assign w_unused_oh = ^w_oh_full[MAX_N-1:N];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
        end else begin
            // A bit re-requested on its grant edge survives the clear.
            r_pending <= (r_pending & ~w_clear) | req_i;
            if (w_load) begin
                r_valid <= 1'b1;
                r_idx   <= w_idx;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_hit && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= IDX_W'(N - 1);
        end else if (w_load) begin
            r_rr_ptr <= (w_idx == '0) ? IDX_W'(N - 1) : w_idx - 1'b1;
        end
    end
`endif

    assign out_valid    = r_valid;
    assign out_idx      = r_idx;
    assign pending_o    = r_pending;
    assign coalesce_cnt = r_cnt;

endmodule

// File: tb/tb_prio_enc_queue.sv
// tb/tb_prio_enc_queue.sv - scoreboard bench for prio_enc_queue (grants checked by a monitor, state by direct checks)
module tb_prio_enc_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_i = 8'h00;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pending_o;
    logic [7:0] coalesce_cnt;
    logic       cnt_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;
    int exp_q[$];

    prio_enc_queue #(.N(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .pending_o   (pending_o),
        .coalesce_cnt(coalesce_cnt),
        .cnt_clr     (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input int idx, input logic [7:0] pend);
        chk({name, ".valid"}, 32'(out_valid), 32'(v));
        if (v) chk({name, ".idx"}, 32'(out_idx), idx);
        chk({name, ".pend"}, 32'(pending_o), 32'(pend));
    endtask

    task automatic do_reset();
        rst = 1'b1; req_i = 8'h00; out_ready = 1'b1; cnt_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic monitor();
        int e;
        while (!done) begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_grant", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_grant", 32'(out_idx), e);
                end
            end
        end
    endtask

    task automatic stimulus();
        // 1: reset with all requests asserted
        rst = 1'b1; req_i = 8'hFF; out_ready = 1'b1;
        tick();
        chk_out("rst0", 1'b0, 0, 8'h00);
        chk("rst0.idx", 32'(out_idx), 0);
        chk("rst0.cnt", 32'(coalesce_cnt), 0);
        tick();
        chk_out("rst1", 1'b0, 0, 8'h00);
        rst = 1'b0; req_i = 8'h00;
        tick();
        chk_out("rst_rel", 1'b0, 0, 8'h00);
        chk("rst_rel.idx", 32'(out_idx), 0);
        chk("rst_rel.cnt", 32'(coalesce_cnt), 0);

        // 2: single request
        req_i = 8'h04;
        tick();
        req_i = 8'h00;
        chk_out("single.p", 1'b0, 0, 8'h04);
        exp_q.push_back(2);
        tick();
        chk_out("single.g", 1'b1, 2, 8'h00);
        tick();
        chk_out("single.e", 1'b0, 0, 8'h00);

        // 3: fixed priority burst
        do_reset();
        req_i = 8'hA5;
        tick();
        req_i = 8'h00;
        exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(0);
        tick(); chk_out("burst7", 1'b1, 7, 8'h25);
        tick(); chk_out("burst5", 1'b1, 5, 8'h05);
        tick(); chk_out("burst2", 1'b1, 2, 8'h01);
        tick(); chk_out("burst0", 1'b1, 0, 8'h00);
        tick(); chk_out("burst_e", 1'b0, 0, 8'h00);

        // 4: backpressure
        do_reset();
        out_ready = 1'b0; req_i = 8'h81;
        tick();
        req_i = 8'h00;
        exp_q.push_back(7); exp_q.push_back(0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("stall%0d", i), 1'b1, 7, 8'h01);
            tick();
        end
        out_ready = 1'b1;
        tick(); chk_out("bp_next", 1'b1, 0, 8'h00);
        tick(); chk_out("bp_e", 1'b0, 0, 8'h00);

        // 5: coalesce while grant 4 is held; first req cycle only re-pends bit 4
        do_reset();
        out_ready = 1'b0; req_i = 8'h10;
        tick();
        req_i = 8'h00;
        exp_q.push_back(4); exp_q.push_back(4);
        tick(); chk_out("co_grant", 1'b1, 4, 8'h00);
        req_i = 8'h10;
        tick();
        chk_out("co_pend", 1'b1, 4, 8'h10);
        chk("co_cnt0", 32'(coalesce_cnt), 0);
        tick(); tick(); tick();
        chk("co_cnt3", 32'(coalesce_cnt), 3);
        for (int i = 0; i < 300; i++) tick();
        chk("co_sat", 32'(coalesce_cnt), 255);
        cnt_clr = 1'b1;
        tick();
        chk("co_clr", 32'(coalesce_cnt), 0);
        cnt_clr = 1'b0;
        tick();
        chk("co_resume", 32'(coalesce_cnt), 1);
        req_i = 8'h00; out_ready = 1'b1;
        tick(); chk_out("co_regrant", 1'b1, 4, 8'h00);
        tick(); chk_out("co_e", 1'b0, 0, 8'h00);
        chk("co_cnt_hold", 32'(coalesce_cnt), 1);

        // 6: re-request on its own grant edge; order depends on build
        do_reset();
        req_i = 8'h81;
        tick();
        req_i = 8'h80;
        exp_q.push_back(7);
`ifdef PRIO_ENC_ROUND_ROBIN_EN
        exp_q.push_back(0); exp_q.push_back(7);
`else
        exp_q.push_back(7); exp_q.push_back(0);
`endif
        tick();
        req_i = 8'h00;
        chk_out("rr_g1", 1'b1, 7, 8'h81);
        tick();
`ifdef PRIO_ENC_ROUND_ROBIN_EN
        chk_out("rr_g2", 1'b1, 0, 8'h80);
        tick(); chk_out("rr_g3", 1'b1, 7, 8'h00);
`else
        chk_out("rr_g2", 1'b1, 7, 8'h01);
        tick(); chk_out("rr_g3", 1'b1, 0, 8'h00);
`endif
        tick(); chk_out("rr_e", 1'b0, 0, 8'h00);

        // 7: reset mid-operation discards the held grant
        do_reset();
        out_ready = 1'b0; req_i = 8'hC0;
        tick();
        req_i = 8'h00;
        tick();
        chk_out("mid_pre", 1'b1, 7, 8'h40);
        rst = 1'b1;
        tick();
        chk_out("mid_rst", 1'b0, 0, 8'h00);
        chk("mid_rst.idx", 32'(out_idx), 0);
        rst = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk_out("mid_after", 1'b0, 0, 8'h00);

        chk("sb_drained", 32'(exp_q.size()), 0);
        done = 1'b1;
    endtask

    initial begin
        fork
            stimulus();
            monitor();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
